// File: rtl/and_arb_pkg.sv
// Shared types for the AND-unit arbiter: FSM state encoding and its width.
package and_arb_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    ACK  = 2'd3
  } state_e;

endpackage

// File: rtl/and_unit_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of req at or above ptr, wrapping.
module rr_picker #(
  parameter  int N_REQ = 4,
  localparam int GW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    ptr,
  output logic             found,
  output logic [GW-1:0]    idx
);

  function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return GW'(s);
  endfunction

  // Scan from the farthest offset down so the nearest candidate is assigned last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[wrap_idx(ptr, i)]) begin
        found = 1'b1;
        idx   = wrap_idx(ptr, i);
      end
    end
  end

endmodule

// File: rtl/and_unit_arbiter.sv
// Round-robin sequencer sharing one registered AND unit among N_REQ requesters.
module and_unit_arbiter
  import and_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int W     = 1,
  localparam int GW    = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] a_in,
  input  logic [N_REQ*W-1:0] b_in,
  output logic [N_REQ-1:0]   ack,
  output logic [W-1:0]       c_out,
  output logic [GW-1:0]      gnt_id,
  output logic               busy,
  output logic [W-1:0]       unit_a,
  output logic [W-1:0]       unit_b,
  input  logic [W-1:0]       unit_c
);

  state_e           state_q, state_d;
  logic [GW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [W-1:0]     c_out_q, c_out_d;
  logic [GW-1:0]    gnt_id_q, gnt_id_d;
  logic [W-1:0]     unit_a_q, unit_a_d;
  logic [W-1:0]     unit_b_q, unit_b_d;

  logic             found;
  logic [GW-1:0]    win_idx;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req   (req),
    .ptr   (ptr_q),
    .found (found),
    .idx   (win_idx)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ack_d    = ack_q;
    c_out_d  = c_out_q;
    gnt_id_d = gnt_id_q;
    unit_a_d = unit_a_q;
    unit_b_d = unit_b_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          unit_a_d = a_in[int'(win_idx)*W +: W];
          unit_b_d = b_in[int'(win_idx)*W +: W];
          gnt_id_d = win_idx;
          state_d  = EXEC;
        end
      end
      EXEC: state_d = CAPT;
      CAPT: begin
        c_out_d          = unit_c;
        ack_d            = '0;
        ack_d[gnt_id_q]  = 1'b1;
        ptr_d            = (gnt_id_q == GW'(N_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
        state_d          = ACK;
      end
      ACK: begin
        ack_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset clears everything, abandoning any transaction in flight without an ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      ack_q    <= '0;
      c_out_q  <= '0;
      gnt_id_q <= '0;
      unit_a_q <= '0;
      unit_b_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ack_q    <= ack_d;
      c_out_q  <= c_out_d;
      gnt_id_q <= gnt_id_d;
      unit_a_q <= unit_a_d;
      unit_b_q <= unit_b_d;
    end
  end

  assign ack    = ack_q;
  assign c_out  = c_out_q;
  assign gnt_id = gnt_id_q;
  assign unit_a = unit_a_q;
  assign unit_b = unit_b_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Directed bench for and_unit_arbiter with a registered AND unit model attached.
module tb_and_unit_arbiter;

  localparam int N  = 4;
  localparam int W  = 1;
  localparam int GW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in, b_in;
  logic [N-1:0]   ack;
  logic [W-1:0]   c_out;
  logic [GW-1:0]  gnt_id;
  logic           busy;
  logic [W-1:0]   unit_a, unit_b, unit_c;

  int vectors = 0;
  int miscompares = 0;

  and_unit_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .ack(ack), .c_out(c_out), .gnt_id(gnt_id), .busy(busy),
    .unit_a(unit_a), .unit_b(unit_b), .unit_c(unit_c)
  );

  always #5 clk = ~clk;

  // Shared AND unit: one-cycle registered a & b.
  always_ff @(posedge clk) unit_c <= unit_a & unit_b;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Hand-computed tables.
  logic [3:0] sweep_a   = 4'b1010;  // entry k uses bit k
  logic [3:0] sweep_b   = 4'b1100;
  logic [3:0] sweep_exp = 4'b1000;  // 0,0,0,1

  initial begin
    // Reset state
    rst_n = 1'b0; req = '0; a_in = '0; b_in = '0;
    step(2);
    chk("rst_ack",    32'(ack),    32'h0);
    chk("rst_c_out",  32'(c_out),  32'h0);
    chk("rst_gnt",    32'(gnt_id), 32'h0);
    chk("rst_busy",   32'(busy),   32'h0);
    chk("rst_unit_a", 32'(unit_a), 32'h0);
    chk("rst_unit_b", 32'(unit_b), 32'h0);
    rst_n = 1'b1;
    step(1);

    // Single request from requester 2
    req = 4'b0100; a_in = 4'b0100; b_in = 4'b0100;
    step(1);
    chk("single_exec_busy", 32'(busy),   32'h1);
    chk("single_exec_gnt",  32'(gnt_id), 32'h2);
    chk("single_exec_ua",   32'(unit_a), 32'h1);
    chk("single_exec_ub",   32'(unit_b), 32'h1);
    chk("single_exec_ack",  32'(ack),    32'h0);
    step(1);
    chk("single_capt_busy", 32'(busy),   32'h1);
    chk("single_capt_ack",  32'(ack),    32'h0);
    step(1);
    chk("single_ack",       32'(ack),    32'h4);
    chk("single_c_out",     32'(c_out),  32'h1);
    chk("single_ack_busy",  32'(busy),   32'h1);
    req = '0;
    step(1);
    chk("single_idle_ack",  32'(ack),    32'h0);
    chk("single_idle_busy", 32'(busy),   32'h0);
    chk("single_hold_c",    32'(c_out),  32'h1);

    // Operand sweep on requester 0 (ptr is 3, only req[0] asserted)
    for (int k = 0; k < 4; k++) begin
      a_in = {3'b000, sweep_a[k]};
      b_in = {3'b000, sweep_b[k]};
      req  = 4'b0001;
      step(3);
      chk($sformatf("sweep%0d_ack", k), 32'(ack),   32'h1);
      chk($sformatf("sweep%0d_c", k),   32'(c_out), 32'(sweep_exp[k]));
      req = '0;
      step(1);
    end

    // Contention from ptr = 0 (after reset); c per requester = b bit
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    req = 4'b1111; a_in = 4'b1111; b_in = 4'b1010;
    for (int t = 0; t < 8; t++) begin
      step(1);
      chk($sformatf("cont%0d_exec_ack", t), 32'(ack), 32'h0);
      step(1);
      chk($sformatf("cont%0d_capt_ack", t), 32'(ack), 32'h0);
      step(1);
      chk($sformatf("cont%0d_ack", t), 32'(ack),    32'(1 << (t % 4)));
      chk($sformatf("cont%0d_gnt", t), 32'(gnt_id), 32'(t % 4));
      chk($sformatf("cont%0d_c", t),   32'(c_out),  32'((t % 4) % 2));
      step(1);
      chk($sformatf("cont%0d_idle_ack", t), 32'(ack), 32'h0);
    end
    req = '0;

    // Pointer wrap: requester 3 alone, then 1001 -> 0 then 3
    a_in = 4'b1001; b_in = 4'b0001;
    req = 4'b1000;
    step(3);
    chk("wrap_a_ack", 32'(ack),   32'h8);
    chk("wrap_a_c",   32'(c_out), 32'h0);
    req = 4'b1001;
    step(1);
    step(3);
    chk("wrap_b_ack", 32'(ack),    32'h1);
    chk("wrap_b_gnt", 32'(gnt_id), 32'h0);
    chk("wrap_b_c",   32'(c_out),  32'h1);
    req = 4'b1000;
    step(1);
    step(3);
    chk("wrap_c_ack", 32'(ack),    32'h8);
    chk("wrap_c_gnt", 32'(gnt_id), 32'h3);
    req = '0;
    step(1);

    // Mid-transaction: drop req[1] and change a_in[1] during EXEC (ptr = 0)
    req = 4'b0010; a_in = 4'b0010; b_in = 4'b0010;
    step(1);
    chk("mid_exec_gnt", 32'(gnt_id), 32'h1);
    req = '0; a_in = 4'b0000;
    step(1);
    chk("mid_capt_ua", 32'(unit_a), 32'h1);
    step(1);
    chk("mid_ack", 32'(ack),   32'h2);
    chk("mid_c",   32'(c_out), 32'h1);
    step(1);

    // Reset during CAPT (ptr = 2, c_out currently 1)
    req = 4'b0100; a_in = 4'b0100; b_in = 4'b0100;
    step(2);
    chk("rcapt_busy", 32'(busy), 32'h1);
    rst_n = 1'b0; req = '0;
    step(1);
    chk("rcapt_busy0", 32'(busy),   32'h0);
    chk("rcapt_ack",   32'(ack),    32'h0);
    chk("rcapt_c",     32'(c_out),  32'h0);
    chk("rcapt_gnt",   32'(gnt_id), 32'h0);
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      step(1);
      chk($sformatf("rcapt_noack%0d", t), 32'(ack), 32'h0);
    end
    req = 4'b1111; a_in = 4'b1111; b_in = 4'b1111;
    step(3);
    chk("rcapt_ptr0_ack", 32'(ack),    32'h1);
    chk("rcapt_ptr0_gnt", 32'(gnt_id), 32'h0);
    req = '0;
    step(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
